// File: rtl/drf_io_pkg.sv
// Shared constants for the memory-mapped I/O port controller:
// register offsets, STATUS bit positions and the default window base.
package drf_io_pkg;

  localparam logic [1:0] REG_DATA_IN  = 2'd0;
  localparam logic [1:0] REG_DATA_OUT = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_RSVD     = 2'd3;

  localparam int ST_IN_FULL      = 0;
  localparam int ST_IN_OVERRUN   = 1;
  localparam int ST_OUT_PENDING  = 2;
  localparam int ST_OUT_OVERFLOW = 3;

  localparam logic [9:0] DEFAULT_BASE_ADDR = 10'h3C0;

endpackage

// File: rtl/drf_io_channel.sv
// One I/O channel: input synchroniser, strobe edge capture, DATA_IN latch,
// output valid/ack handshake and the STATUS bits.
// Ports: clk/rst; async port_in/port_in_strobe; bus-side rd/wr/clear
// strobes and write data; port_out/valid/ack; data_in and status to mux.
module drf_io_channel
  import drf_io_pkg::*;
#(
  parameter int PORT_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PORT_W-1:0] port_in,
  input  logic              port_in_strobe,
  input  logic              rd_data_in,
  input  logic              wr_data_out,
  input  logic [PORT_W-1:0] wdata,
  input  logic              clr_overrun,
  input  logic              clr_overflow,
  input  logic              port_out_ack,
  output logic [PORT_W-1:0] data_in,
  output logic [PORT_W-1:0] port_out,
  output logic              port_out_valid,
  output logic [7:0]        status
);

  logic [SYNC_STAGES-1:0][PORT_W-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0]             stb_sync_q, stb_sync_d;
  logic                               stb_prev_q, stb_prev_d;
  logic [PORT_W-1:0]                  data_in_q, data_in_d;
  logic                               in_full_q, in_full_d;
  logic                               overrun_q, overrun_d;
  logic [PORT_W-1:0]                  port_out_q, port_out_d;
  logic                               valid_q, valid_d;
  logic                               overflow_q, overflow_d;
  logic                               capture;

  always_comb begin
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], port_in};
    stb_sync_d = {stb_sync_q[SYNC_STAGES-2:0], port_in_strobe};
    stb_prev_d = stb_sync_q[SYNC_STAGES-1];
    capture    = stb_sync_q[SYNC_STAGES-1] & ~stb_prev_q;

    data_in_d  = data_in_q;
    in_full_d  = in_full_q;
    // A new overrun in the same cycle as its clear wins: it is newer news.
    overrun_d  = overrun_q & ~clr_overrun;
    if (capture) begin
      in_full_d = 1'b1;
      // A concurrent DATA_IN read frees the slot, so no overrun.
      if (!in_full_q || rd_data_in) data_in_d = din_sync_q[SYNC_STAGES-1];
      else overrun_d = 1'b1;
    end else if (rd_data_in) begin
      in_full_d = 1'b0;
    end

    port_out_d = port_out_q;
    valid_d    = valid_q;
    overflow_d = overflow_q & ~clr_overflow;
    if (wr_data_out) begin
      // Same-cycle ack retires the old word and makes room for this one.
      if (!valid_q || port_out_ack) begin
        port_out_d = wdata;
        valid_d    = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (port_out_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_sync_q <= '0;
      stb_sync_q <= '0;
      stb_prev_q <= 1'b0;
      data_in_q  <= '0;
      in_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      port_out_q <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      din_sync_q <= din_sync_d;
      stb_sync_q <= stb_sync_d;
      stb_prev_q <= stb_prev_d;
      data_in_q  <= data_in_d;
      in_full_q  <= in_full_d;
      overrun_q  <= overrun_d;
      port_out_q <= port_out_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    status                  = '0;
    status[ST_IN_FULL]      = in_full_q;
    status[ST_IN_OVERRUN]   = overrun_q;
    status[ST_OUT_PENDING]  = valid_q;
    status[ST_OUT_OVERFLOW] = overflow_q;
  end

  assign data_in        = data_in_q;
  assign port_out       = port_out_q;
  assign port_out_valid = valid_q;

endmodule

// File: rtl/drf_port_controller.sv
// Memory-mapped I/O controller: decodes a 4-register-per-channel window
// on the 10-bit bus, drives the read mux and fans out NUM_PORTS channels.
// Ports: clk/rst; bus in_addr/in_write_en/in_read_en/in_data,
// out_data/out_drive; per-channel port_in/strobe, port_out/valid/ack.
module drf_port_controller
  import drf_io_pkg::*;
#(
  parameter int         NUM_PORTS   = 4,
  parameter int         PORT_W      = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [9:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  in_addr,
  input  logic                        in_write_en,
  input  logic                        in_read_en,
  input  logic [7:0]                  in_data,
  output logic [7:0]                  out_data,
  output logic                        out_drive,
  input  logic [NUM_PORTS*PORT_W-1:0] port_in,
  input  logic [NUM_PORTS-1:0]        port_in_strobe,
  output logic [NUM_PORTS*PORT_W-1:0] port_out,
  output logic [NUM_PORTS-1:0]        port_out_valid,
  input  logic [NUM_PORTS-1:0]        port_out_ack
);

  logic [10:0] addr_x;
  logic [10:0] win_lo;
  logic [10:0] win_hi;
  logic        hit;
  logic [9:0]  offset;
  logic [7:0]  ch_idx;
  logic [1:0]  reg_sel;
  logic        unused_wdata;

  // Extra top bit keeps the window end from wrapping at 10'h3FF.
  assign addr_x  = {1'b0, in_addr};
  assign win_lo  = {1'b0, BASE_ADDR};
  assign win_hi  = win_lo + 11'(4 * NUM_PORTS);
  assign hit     = (addr_x >= win_lo) && (addr_x < win_hi);
  assign offset  = in_addr - BASE_ADDR;
  assign ch_idx  = offset[9:2];
  assign reg_sel = offset[1:0];

  assign unused_wdata = ^in_data;

  logic [PORT_W-1:0] din_w  [NUM_PORTS];
  logic [PORT_W-1:0] pout_w [NUM_PORTS];
  logic [7:0]        stat_w [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    logic sel;
    logic rd_in;
    logic wr_out;
    logic wr_st;

    assign sel    = hit && (ch_idx == 8'(g));
    assign rd_in  = in_read_en && sel && (reg_sel == REG_DATA_IN);
    assign wr_out = in_write_en && sel && (reg_sel == REG_DATA_OUT);
    assign wr_st  = in_write_en && sel && (reg_sel == REG_STATUS);

    drf_io_channel #(
      .PORT_W      (PORT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk            (clk),
      .rst            (rst),
      .port_in        (port_in[g*PORT_W +: PORT_W]),
      .port_in_strobe (port_in_strobe[g]),
      .rd_data_in     (rd_in),
      .wr_data_out    (wr_out),
      .wdata          (in_data[PORT_W-1:0]),
      .clr_overrun    (wr_st && in_data[ST_IN_OVERRUN]),
      .clr_overflow   (wr_st && in_data[ST_OUT_OVERFLOW]),
      .port_out_ack   (port_out_ack[g]),
      .data_in        (din_w[g]),
      .port_out       (pout_w[g]),
      .port_out_valid (port_out_valid[g]),
      .status         (stat_w[g])
    );

    assign port_out[g*PORT_W +: PORT_W] = pout_w[g];
  end

  assign out_drive = in_read_en && hit;

  always_comb begin
    out_data = 8'h00;
    if (out_drive) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (ch_idx == 8'(i)) begin
          unique case (1'b1)
            reg_sel == REG_DATA_IN:  out_data = 8'(din_w[i]);
            reg_sel == REG_DATA_OUT: out_data = 8'(pout_w[i]);
            reg_sel == REG_STATUS:   out_data = stat_w[i];
            default:                 out_data = 8'h00;
          endcase
        end
      end
    end
  end

endmodule
